score_sprite: RTL and testbench

- Parametrised multi-digit successor to the single-digit sprite: renders an unsigned binary value as DIGITS decimal glyphs at a run-time screen position on the VGA raster.
- Contains a sequential binary-to-BCD converter (shift-add-3), an optional leading-zero blanking mode, integer pixel scaling and a 2-stage pixel pipeline.
- Sits between the game score/round logic and the VGA colour mux.

---
 rtl/score_sprite.sv | 209 ++++++++++++++++++++
 tb/tb_score_sprite.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_sprite.sv
// Multi-digit decimal score sprite: serial binary-to-BCD conversion into a held
// display register, rendered as 5x7 glyphs through a 2-stage pixel pipeline.
module score_sprite #(
    parameter int         DIGITS     = 3,
    parameter int         VAL_W      = 10,
    parameter int         SCALE_LOG2 = 0,
    parameter bit         BLANK_LZ   = 1'b1,
    parameter logic [2:0] FG         = 3'b111,
    parameter logic [2:0] BG         = 3'b000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       xvga,
    input  logic [7:0]       yvga,
    input  logic [8:0]       x_pos,
    input  logic [7:0]       y_pos,
    input  logic [VAL_W-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic             ovf,
    output logic             active,
    output logic [2:0]       color
);
    localparam int BCD_W  = 4 * (DIGITS + 1);
    localparam int DISP_W = 4 * DIGITS;
    localparam int CNT_W  = $clog2(VAL_W + 1);
    localparam int BOX_W  = (6 * DIGITS) << SCALE_LOG2;
    localparam int BOX_H  = 8 << SCALE_LOG2;
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(VAL_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [VAL_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
    logic                lost_q, lost_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DISP_W-1:0]   disp_q, disp_d;
    logic                ovf_q, ovf_d;

    logic [9:0] rx, cx, dig_idx;
    logic [8:0] ry;
    logic [3:0] dig_nib;
    logic       zero_run, lit;
    logic       vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic [3:0] nib_p1_q, nib_p1_d;
    logic [2:0] col_p1_q, col_p1_d, row_p1_q, row_p1_d;
    logic [2:0] color_p2_q, color_p2_d;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic glyph_lit(input logic [3:0] n, input logic [2:0] c,
                                       input logic [2:0] r);
        logic [34:0] g;
        logic [4:0]  rb;
        logic        l;
        case (n)
            4'd0:    g = 35'b01110_10001_10011_10101_11001_10001_01110;
            4'd1:    g = 35'b00100_01100_00100_00100_00100_00100_01110;
            4'd2:    g = 35'b01110_10001_00001_00010_00100_01000_11111;
            4'd3:    g = 35'b11111_00010_00100_00010_00001_10001_01110;
            4'd4:    g = 35'b00010_00110_01010_10010_11111_00010_00010;
            4'd5:    g = 35'b11111_10000_11110_00001_00001_10001_01110;
            4'd6:    g = 35'b00110_01000_10000_11110_10001_10001_01110;
            4'd7:    g = 35'b11111_00001_00010_00100_01000_01000_01000;
            4'd8:    g = 35'b01110_10001_10001_01110_10001_10001_01110;
            4'd9:    g = 35'b01110_10001_10001_01111_00001_00010_01100;
            default: g = '0;
        endcase
        case (r)
            3'd0:    rb = g[34:30];
            3'd1:    rb = g[29:25];
            3'd2:    rb = g[24:20];
            3'd3:    rb = g[19:15];
            3'd4:    rb = g[14:10];
            3'd5:    rb = g[9:5];
            3'd6:    rb = g[4:0];
            default: rb = '0;
        endcase
        case (c)
            3'd0:    l = rb[4];
            3'd1:    l = rb[3];
            3'd2:    l = rb[2];
            3'd3:    l = rb[1];
            3'd4:    l = rb[0];
            default: l = 1'b0;
        endcase
        return l;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            vld_p1_q   <= 1'b0;
            nib_p1_q   <= '0;
            col_p1_q   <= '0;
            row_p1_q   <= '0;
            vld_p2_q   <= 1'b0;
            color_p2_q <= '0;
        end else begin
            state_q    <= state_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            vld_p1_q   <= vld_p1_d;
            nib_p1_q   <= nib_p1_d;
            col_p1_q   <= col_p1_d;
            row_p1_q   <= row_p1_d;
            vld_p2_q   <= vld_p2_d;
            color_p2_q <= color_p2_d;
        end
    end

    // Conversion scratch registers are always reloaded by load before use.
    always_ff @(posedge clk) begin
        bin_q  <= bin_d;
        bcd_q  <= bcd_d;
        lost_q <= lost_d;
        cnt_q  <= cnt_d;
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = S_SHIFT;
        end else begin
            case (state_q)
                S_SHIFT: if (cnt_q == LAST_SHIFT) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        lost_d  = lost_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        bcd_adj = add3(bcd_q);
        busy    = (state_q != S_IDLE);
        if (state_q == S_SHIFT) begin
            bcd_d  = {bcd_adj[BCD_W-2:0], bin_q[VAL_W-1]};
            bin_d  = bin_q << 1;
            lost_d = lost_q | bcd_adj[BCD_W-1];
            cnt_d  = cnt_q + 1'b1;
        end
        // A nonzero top nibble or a bit shifted out means the value needs more digits.
        if (state_q == S_DONE) begin
            if (lost_q || (bcd_q[BCD_W-1 -: 4] != 4'd0)) begin
                disp_d = {DIGITS{4'h9}};
                ovf_d  = 1'b1;
            end else begin
                disp_d = bcd_q[DISP_W-1:0];
                ovf_d  = 1'b0;
            end
        end
        if (load) begin
            bin_d  = value;
            bcd_d  = '0;
            lost_d = 1'b0;
            cnt_d  = '0;
        end
    end

    // Stage 1: box test, digit select with leading-zero blanking, glyph coordinates
    always_comb begin
        rx       = {1'b0, xvga} - {1'b0, x_pos};
        ry       = {1'b0, yvga} - {1'b0, y_pos};
        cx       = rx >> SCALE_LOG2;
        dig_idx  = cx / 10'd6;
        vld_p1_d = (xvga >= x_pos) && (int'(rx) < BOX_W) &&
                   (yvga >= y_pos) && (int'(ry) < BOX_H);
        col_p1_d = 3'(cx % 10'd6);
        row_p1_d = 3'(ry >> SCALE_LOG2);
        nib_p1_d = 4'hF;
        zero_run = 1'b1;
        dig_nib  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig_nib  = disp_q[4*(DIGITS-1-i) +: 4];
            zero_run = zero_run && (dig_nib == 4'd0);
            if (dig_idx == 10'(i)) begin
                nib_p1_d = (BLANK_LZ && zero_run && (i != DIGITS - 1)) ? 4'hF : dig_nib;
            end
        end
    end

    // Stage 2: font lookup and colour
    always_comb begin
        lit        = glyph_lit(nib_p1_q, col_p1_q, row_p1_q);
        vld_p2_d   = vld_p1_q;
        color_p2_d = vld_p1_q ? (lit ? FG : BG) : 3'b000;
    end

    assign ovf    = ovf_q;
    assign active = vld_p2_q;
    assign color  = color_p2_q;

endmodule

// File: tb/tb_score_sprite.sv
// Randomised bench for score_sprite with an arithmetic reference model; runs an
// unscaled and a 2x-scaled instance side by side on the same raster.
module tb_score_sprite;
    localparam int DIGITS = 3;
    localparam int VAL_W  = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] xvga, x_pos;
    logic [7:0] yvga, y_pos;
    logic [9:0] value;
    logic       load;
    logic       busy0, ovf0, active0, busy1, ovf1, active1;
    logic [2:0] color0, color1;

    int total = 0;
    int bad   = 0;

    int         m_disp, m_val, m_cnt;
    bit         m_ovf, m_pend;
    logic [3:0] p1a, p1b, p2a, p2b;

    score_sprite #(.DIGITS(DIGITS), .VAL_W(VAL_W), .SCALE_LOG2(0), .BLANK_LZ(1'b1),
                   .FG(3'b111), .BG(3'b000)) u_dut (
        .clk(clk), .rst(rst), .xvga(xvga), .yvga(yvga), .x_pos(x_pos), .y_pos(y_pos),
        .value(value), .load(load), .busy(busy0), .ovf(ovf0), .active(active0), .color(color0));

    score_sprite #(.DIGITS(DIGITS), .VAL_W(VAL_W), .SCALE_LOG2(1), .BLANK_LZ(1'b1),
                   .FG(3'b111), .BG(3'b000)) u_dut_s1 (
        .clk(clk), .rst(rst), .xvga(xvga), .yvga(yvga), .x_pos(x_pos), .y_pos(y_pos),
        .value(value), .load(load), .busy(busy1), .ovf(ovf1), .active(active1), .color(color1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic bit font_lit(input int d, input int r, input int c);
        string rows[7];
        case (d)
            0: rows = '{".###.", "#...#", "#..##", "#.#.#", "##..#", "#...#", ".###."};
            1: rows = '{"..#..", ".##..", "..#..", "..#..", "..#..", "..#..", ".###."};
            2: rows = '{".###.", "#...#", "....#", "...#.", "..#..", ".#...", "#####"};
            3: rows = '{"#####", "...#.", "..#..", "...#.", "....#", "#...#", ".###."};
            4: rows = '{"...#.", "..##.", ".#.#.", "#..#.", "#####", "...#.", "...#."};
            5: rows = '{"#####", "#....", "####.", "....#", "....#", "#...#", ".###."};
            6: rows = '{"..##.", ".#...", "#....", "####.", "#...#", "#...#", ".###."};
            7: rows = '{"#####", "....#", "...#.", "..#..", ".#...", ".#...", ".#..."};
            8: rows = '{".###.", "#...#", "#...#", ".###.", "#...#", "#...#", ".###."};
            default: rows = '{".###.", "#...#", "#...#", ".####", "....#", "...#.", ".##.."};
        endcase
        return rows[r].getc(c) == 8'h23;
    endfunction

    // Expected {active, color} for a raster point showing number n.
    function automatic logic [3:0] exp_pix(input int x, input int y, input int xp,
                                           input int yp, input int n, input int s);
        int  w, h, cx, d, c, r, place;
        bit  l;
        w = (6 * DIGITS) << s;
        h = 8 << s;
        if (x < xp || x - xp >= w || y < yp || y - yp >= h) return 4'b0000;
        cx    = (x - xp) >> s;
        d     = cx / 6;
        c     = cx % 6;
        r     = (y - yp) >> s;
        place = pow10(DIGITS - 1 - d);
        l     = 1'b0;
        if (!((n / place) == 0 && d != DIGITS - 1) && c < 5 && r < 7)
            l = font_lit((n / place) % 10, r, c);
        return {1'b1, l ? 3'b111 : 3'b000};
    endfunction

    task automatic tick();
        logic [3:0] pa, pb;
        bit         ld;
        int         v;
        pa = exp_pix(int'(xvga), int'(yvga), int'(x_pos), int'(y_pos), m_disp, 0);
        pb = exp_pix(int'(xvga), int'(yvga), int'(x_pos), int'(y_pos), m_disp, 1);
        ld = load;
        v  = int'(value);
        @(posedge clk);
        #1;
        p2a = p1a; p2b = p1b;
        p1a = pa;  p1b = pb;
        if (m_pend) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_pend = 1'b0;
                m_ovf  = (m_val > pow10(DIGITS) - 1);
                m_disp = m_ovf ? pow10(DIGITS) - 1 : m_val;
            end
        end
        if (ld) begin
            m_pend = 1'b1;
            m_cnt  = VAL_W + 1;
            m_val  = v;
        end
        chk("busy", int'(busy0), int'(m_pend));
        chk("busy_s1", int'(busy1), int'(m_pend));
        chk("ovf", int'(ovf0), int'(m_ovf));
        chk("ovf_s1", int'(ovf1), int'(m_ovf));
        chk("active", int'(active0), int'(p2a[3]));
        chk("color", int'(color0), int'(p2a[2:0]));
        chk("active_s1", int'(active1), int'(p2b[3]));
        chk("color_s1", int'(color1), int'(p2b[2:0]));
    endtask

    task automatic model_clear();
        m_disp = 0; m_val = 0; m_cnt = 0; m_ovf = 1'b0; m_pend = 1'b0;
        p1a = '0; p1b = '0; p2a = '0; p2b = '0;
    endtask

    task automatic do_reset();
        load = 1'b0;
        rst  = 1'b1;
        #2;
        chk("rst_busy", int'(busy0), 0);
        chk("rst_ovf", int'(ovf0), 0);
        chk("rst_active", int'(active0), 0);
        chk("rst_color", int'(color0), 0);
        chk("rst_active_s1", int'(active1), 0);
        chk("rst_color_s1", int'(color1), 0);
        model_clear();
        #2;
        rst = 1'b0;
    endtask

    task automatic do_load(input int v);
        value = 10'(v);
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_pix(input int x, input int y);
        xvga = 9'(x);
        yvga = 8'(y);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0;
        xvga = '0; yvga = '0; x_pos = 9'd100; y_pos = 8'd50;
        model_clear();
        #12;
        chk("por_busy", int'(busy0), 0);
        chk("por_ovf", int'(ovf0), 0);
        chk("por_active", int'(active0), 0);
        chk("por_color", int'(color0), 0);
        rst = 1'b0;

        // Reset in the middle of a conversion, then confirm no late commit.
        set_pix(114, 51);
        do_load(123);
        run(3);
        do_reset();
        for (int i = 0; i < 24; i++) begin
            set_pix(112 + (i % 6), 50 + (i % 8));
            tick();
        end

        // Conversion timing and glyph pixel.
        set_pix(102, 50);
        do_load(907);
        run(14);

        // Overflow then small value with blanking.
        do_load(1000);
        run(13);
        do_load(5);
        run(11);
        set_pix(101, 50);
        run(3);

        // Geometry sweep along one row.
        do_load(111);
        run(12);
        for (int x = 99; x <= 118; x++) begin
            set_pix(x, 52);
            tick();
        end
        run(2);

        // Scaled glyph columns and rows.
        do_load(1);
        run(12);
        for (int y = 48; y <= 67; y++) begin
            for (int x = 122; x <= 137; x++) begin
                set_pix(x, y);
                tick();
            end
        end

        // Restart while busy, then a load landing on the commit cycle.
        set_pix(104, 53);
        do_load(250);
        run(2);
        do_load(7);
        run(14);
        do_load(42);
        run(VAL_W);
        do_load(318);
        run(14);

        // Randomised raster, positions and loads.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    x_pos = 9'($urandom_range(0, 511));
                    y_pos = 8'($urandom_range(0, 255));
                end else begin
                    x_pos = 9'($urandom_range(480, 511));
                    y_pos = 8'($urandom_range(236, 255));
                end
            end
            if ($urandom_range(0, 3) == 0)
                set_pix(int'($urandom_range(0, 511)), int'($urandom_range(0, 255)));
            else
                set_pix(int'(x_pos) + int'($urandom_range(0, 44)) - 3,
                        int'(y_pos) + int'($urandom_range(0, 22)) - 3);
            if ($urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 5))
                    0:       value = 10'd999;
                    1:       value = 10'd1000;
                    2:       value = 10'($urandom_range(0, 9));
                    3:       value = 10'($urandom_range(0, 99));
                    default: value = 10'($urandom_range(0, 1023));
                endcase
                load = 1'b1;
            end
            tick();
            load = 1'b0;
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
